// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Holds the frame state encoding and the counter-width helper.
package fifo_uart_pkg;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Width needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        w = w + 1;
        v = v >> 1;
      end
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit and flags
// the last cycle of each period. Held at zero while clear is high.
module baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int              CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign bit_end = !clear && (r_cnt == LAST);

  // Restart on every boundary so each bit gets exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (clear || bit_end)  r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte at a time from the FIFO read port and sends it as an
// 8N1 UART frame, with an optional even-parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout,
  output logic              fifo_read_enable,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  tx_state_t             r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_byte_done;
  logic                  w_bit_end;
  logic                  w_baud_clear;

  // Baud timer only runs while a bit is actually on the line.
  assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_baud_clear),
    .bit_end(w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (tx_enable && !fifo_empty) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          // Read data is valid at this edge, one cycle after the pop.
          r_shift   <= fifo_dataout;
          r_parity  <= PARITY_EN ? ^fifo_dataout : 1'b0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_state   <= START;
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == LAST_BIT) begin
              if (PARITY_EN) begin
                r_tx    <= r_parity;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
              r_tx      <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read_enable = (r_state == FETCH);
  assign tx               = r_tx;
  assign busy             = r_busy;
  assign byte_done        = r_byte_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a plain and a parity instance share the stimulus;
// a frame-timing model built from cycle arithmetic predicts every output.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tx_en = 1'b0;
  logic [1:0]      empty = 2'b11;
  logic [1:0][7:0] dout = '0;
  logic [1:0]      re_o, tx_o, busy_o, bd_o;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_np (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(empty[0]),
    .fifo_dataout(dout[0]), .fifo_read_enable(re_o[0]), .tx(tx_o[0]),
    .busy(busy_o[0]), .byte_done(bd_o[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_par (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(empty[1]),
    .fifo_dataout(dout[1]), .fifo_read_enable(re_o[1]), .tx(tx_o[1]),
    .busy(busy_o[1]), .byte_done(bd_o[1]));

  int          n_cmp = 0;
  int          n_err = 0;
  int          k = 0;
  bit          m_act [2];
  int          m_t0  [2];
  logic [7:0]  m_byte[2];
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  pend  [2];
  bit          pend_v[2];
  int          rd_cnt[2];
  int          bd_cnt[2];
  int          bcnt  [2];
  logic [10:0] cap   [2];
  logic [10:0] fr0[$];
  logic [10:0] fr1[$];
  int          br0[$];
  int          br1[$];
  int          gq0[$];
  int          hcnt = 0;

  function automatic int flen(int i);
    return 2 + ((i == 0) ? 10 : 11) * CPB;
  endfunction

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  // Frame bit idx of a byte: start, 8 data LSB first, [even parity], stop.
  function automatic int exp_bit(int i, logic [7:0] b, int idx);
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
    if (i == 1 && idx == 9) return $countones(b) % 2;
    return 1;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, k);
    end
  endtask

  task automatic qpush(int i, logic [7:0] b);
    if (i == 0) q0.push_back(b); else q1.push_back(b);
    empty[i] = 1'b0;
  endtask

  task automatic push_both(logic [7:0] b);
    qpush(0, b);
    qpush(1, b);
  endtask

  task automatic clear_caps();
    fr0.delete(); fr1.delete(); br0.delete(); br1.delete(); gq0.delete();
    for (int i = 0; i < 2; i++) begin
      bcnt[i] = 0;
      cap[i]  = '0;
    end
  endtask

  task automatic check_outputs(int i);
    int d;
    int len;
    bit a;
    int etx;
    d   = k - m_t0[i];
    len = flen(i);
    a   = m_act[i];
    etx = (a && d >= 2 && d < len) ? exp_bit(i, m_byte[i], (d - 2) / CPB) : 1;
    chk($sformatf("tx[%0d]", i),        int'(tx_o[i]),   etx);
    chk($sformatf("busy[%0d]", i),      int'(busy_o[i]), int'(a && d < len));
    chk($sformatf("read_en[%0d]", i),   int'(re_o[i]),   int'(a && d == 0));
    chk($sformatf("byte_done[%0d]", i), int'(bd_o[i]),   int'(a && d == len));
    if (a && d >= 2 && d < len && ((d - 2) % CPB) == CPB / 2)
      cap[i][(d - 2) / CPB] = tx_o[i];
    if (a && d == len) begin
      if (i == 0) fr0.push_back(cap[i]); else fr1.push_back(cap[i]);
      cap[i] = '0;
    end
    if (busy_o[i]) bcnt[i]++;
    else if (bcnt[i] > 0) begin
      if (i == 0) br0.push_back(bcnt[i]); else br1.push_back(bcnt[i]);
      bcnt[i] = 0;
    end
    if (bd_o[i]) bd_cnt[i]++;
    if (i == 0) begin
      if (tx_o[0]) hcnt++;
      else begin
        if (a && d == 2) gq0.push_back(hcnt);
        hcnt = 0;
      end
    end
  endtask

  // One clock: model update at the edge, FIFO data update just after it,
  // output comparison and FIFO pop handling at the falling edge.
  task automatic tick();
    @(posedge clk);
    k++;
    for (int i = 0; i < 2; i++) begin
      if (rst) m_act[i] = 1'b0;
      else begin
        if (m_act[i] && (k - m_t0[i]) > flen(i)) m_act[i] = 1'b0;
        if (!m_act[i] && tx_en && qsize(i) > 0) begin
          m_act[i]  = 1'b1;
          m_t0[i]   = k;
          m_byte[i] = qfront(i);
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++)
      if (pend_v[i]) begin
        dout[i]   = pend[i];
        pend_v[i] = 1'b0;
      end
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        check_outputs(i);
        if (re_o[i]) begin
          rd_cnt[i]++;
          if (qsize(i) > 0) begin
            pend[i]   = qfront(i);
            pend_v[i] = 1'b1;
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          end
          empty[i] = (qsize(i) == 0);
        end
      end
    end
  endtask

  task automatic wait_done(string nm);
    int n;
    n = 0;
    repeat (3) tick();
    while ((m_act[0] || m_act[1] || busy_o != 2'b00) && n < 3000) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, int'(n < 3000), 1);
  endtask

  task automatic wait_phase(string nm, int target);
    int n;
    n = 0;
    while (!(m_act[0] && (k - m_t0[0]) == target) && n < 500) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, int'(n < 500), 1);
  endtask

  int r0, r1, b0, b1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_t0[i] = 0; m_byte[i] = '0; pend[i] = '0;
      pend_v[i] = 1'b0; rd_cnt[i] = 0; bd_cnt[i] = 0; bcnt[i] = 0; cap[i] = '0;
    end
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx",        int'(tx_o),   3);
    chk("rst_busy",      int'(busy_o), 0);
    chk("rst_byte_done", int'(bd_o),   0);
    chk("rst_read_en",   int'(re_o),   0);
    rst   = 1'b0;
    tx_en = 1'b1;

    // Empty FIFO: nothing may happen
    repeat (50) tick();
    chk("t1_no_pop0", rd_cnt[0], 0);
    chk("t1_no_pop1", rd_cnt[1], 0);

    // Single byte 0x0A
    clear_caps();
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; b0 = bd_cnt[0]; b1 = bd_cnt[1];
    push_both(8'h0A);
    wait_done("t2");
    chk("t2_pops0", rd_cnt[0] - r0, 1);
    chk("t2_pops1", rd_cnt[1] - r1, 1);
    chk("t2_done0", bd_cnt[0] - b0, 1);
    chk("t2_done1", bd_cnt[1] - b1, 1);
    chk("t2_nframes", fr0.size(), 1);
    if (fr0.size() >= 1) chk("t2_frame0", int'(fr0[0]), 11'h214);
    if (fr1.size() >= 1) chk("t2_frame1", int'(fr1[0]), 11'h414);
    if (br0.size() >= 1) chk("t2_busy_len0", br0[0], 42);
    if (br1.size() >= 1) chk("t2_busy_len1", br1[0], 46);

    // Back-to-back 0x0D, 0x7A; parity instance covers the 11-bit frame
    clear_caps();
    r0 = rd_cnt[0];
    push_both(8'h0D);
    push_both(8'h7A);
    wait_done("t3");
    chk("t3_pops0", rd_cnt[0] - r0, 2);
    chk("t3_nframes0", fr0.size(), 2);
    chk("t3_nframes1", fr1.size(), 2);
    if (fr0.size() >= 2) begin
      chk("t3_frame0a", int'(fr0[0]), 11'h21A);
      chk("t3_frame0b", int'(fr0[1]), 11'h2F4);
    end
    if (fr1.size() >= 2) begin
      chk("t3_frame1a", int'(fr1[0]), 11'h61A);
      chk("t4_frame1b", int'(fr1[1]), 11'h6F4);
    end
    if (br1.size() >= 2) chk("t4_busy_len1", br1[1], 46);
    chk("t3_gaps", int'(gq0.size() >= 2), 1);
    if (gq0.size() >= 2) chk("t3_gap_high", gq0[1], 7);

    // tx_enable low holds off pops; drop mid-frame lets the frame finish
    tx_en = 1'b0;
    push_both(8'h33);
    push_both(8'h55);
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; b0 = bd_cnt[0]; b1 = bd_cnt[1];
    repeat (100) tick();
    chk("t5_hold0", rd_cnt[0] - r0, 0);
    chk("t5_hold1", rd_cnt[1] - r1, 0);
    tx_en = 1'b1;
    wait_phase("t5_data", 2 + CPB + 1);
    tx_en = 1'b0;
    wait_done("t5");
    chk("t5_pops0", rd_cnt[0] - r0, 1);
    chk("t5_pops1", rd_cnt[1] - r1, 1);
    chk("t5_done0", bd_cnt[0] - b0, 1);
    chk("t5_done1", bd_cnt[1] - b1, 1);

    // Reset during the third data bit of 0x55
    tx_en = 1'b1;
    wait_phase("t6_data", 2 + 3 * CPB + 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx",   int'(tx_o),   3);
    chk("t6_rst_busy", int'(busy_o), 0);
    repeat (3) tick();
    rst = 1'b0;
    clear_caps();
    push_both(8'hC3);
    wait_done("t6");
    chk("t6_nframes", fr0.size(), 1);
    if (fr0.size() >= 1) chk("t6_frame0", int'(fr0[0]), 11'h386);
    if (fr1.size() >= 1) chk("t6_frame1", int'(fr1[0]), 11'h586);
    if (br0.size() >= 1) chk("t6_busy_len0", br0[0], 42);

    // Random traffic and enable toggling, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 7) == 0) begin
        logic [7:0] b;
        b = 8'($urandom);
        for (int i = 0; i < 2; i++)
          if (qsize(i) < 16) qpush(i, b);
      end
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    wait_done("drain");
    chk("drain_empty0", qsize(0), 0);
    chk("drain_empty1", qsize(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain-side companion of the team's 16x8 FIFO. Pops bytes from the FIFO read port and transmits each as a UART frame on a single serial line: 8N1, with optional even parity. Sits between the FIFO read port (read_enable / dataout / empty) and the chip-level tx pin. Pops one byte at a time, and only when it can start a frame immediately.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>= 2).
PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
tx_enable  input  1  permits starting a new frame; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_dataout  input  8  FIFO read data; valid on the edge after the edge at which read_enable was sampled.
fifo_read_enable  output  1  pop request to FIFO; exactly one cycle per byte.
tx  output  1  serial line; idle high.
busy  output  1  high in every state except IDLE.
byte_done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, fifo_read_enable=0, byte_done=0.
  - State=IDLE; bit counter, baud counter and shift register cleared.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - Go to FETCH when the edge samples fifo_empty=0 and tx_enable=1.
  - Otherwise stay; tx=1.
- FETCH: one cycle; fifo_read_enable=1 (decoded from the state register, glitch-free). Always go to LOAD.
- LOAD: one cycle. Capture fifo_dataout into the shift register. If PARITY_EN, compute parity = XOR of the 8 bits. Go to START.
- Launch latency: let E0 be the IDLE sampling edge. FETCH follows E0, LOAD follows E1, and tx falls at E2.
- Each serial bit lasts exactly CLKS_PER_BIT cycles, timed by the baud counter. The baud counter restarts at 0 on every bit boundary.
- START: tx=0.
- DATA: 8 bits, LSB first; the shift register shifts right at each bit boundary.
- PARITY: present only if PARITY_EN=1; tx=parity bit.
- STOP: tx=1.
  - At the end of the stop bit: pulse byte_done for one cycle (registered, coincides with the first IDLE cycle) and go to IDLE.
- Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back frames: after a stop bit, tx stays high for exactly 3 extra cycles (IDLE, FETCH, LOAD) before the next start bit. There is no other inter-frame gap.
- tx_enable is ignored outside IDLE. Dropping it mid-frame lets the current frame finish; no further pop occurs.
- fifo_empty is ignored outside IDLE.
- Reset mid-frame: tx returns high at once and the in-flight byte is discarded. The FIFO has already popped it, and that loss is accepted.
- tx, busy and byte_done are registered outputs.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum (IDLE..STOP);
  - DATA_W=8;
  - the bit-count width constant;
  - the baud-counter width function clog2(CLKS_PER_BIT).
- Sub-module baud_counter (parameter CLKS_PER_BIT):
  - inputs clk, rst, clear;
  - output bit_end, which pulses on the last cycle of a bit period.

Test Plan:
1. Reset, then 50 cycles with fifo_empty=1 and tx_enable=1 -> tx=1, busy=0, byte_done=0, no fifo_read_enable pulse.
2. CLKS_PER_BIT=4, FIFO holds 0x0A -> one fifo_read_enable pulse; tx falls 2 edges after E0; tx sequence 0,0,1,0,1,0,0,0,0,1, each bit 4 cycles; one byte_done; busy high for 42 cycles.
3. FIFO holds 0x0D then 0x7A -> two read pulses; frames 0,1,0,1,1,0,0,0,0,1 then 0,0,1,0,1,1,1,1,0,1; tx high for exactly 4+3 cycles between the first frame's stop start and the second start bit.
4. PARITY_EN=1, byte 0x7A -> 11-bit frame with parity bit 1 (five ones) before the stop bit; 44 cycles per frame.
5. tx_enable=0 with a non-empty FIFO -> no pop for 100 cycles. Raise tx_enable, then drop it during DATA -> frame completes, byte_done pulses once, no second pop.
6. Assert rst during the 3rd data bit -> tx=1 and busy=0 immediately. After release, with the FIFO non-empty -> a fresh frame with the next FIFO byte, full timing intact.
